// File: rtl/lpc_uart_fifo.sv
// LPC I/O-cycle target with a 16550-subset UART: RX/TX FIFOs, LSR error flags,
// scratch register and a level interrupt.
module lpc_uart_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h03F8,
  parameter int unsigned CLK_DIV   = 286,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  inout  wire  [3:0] lpc_ad,
  input  logic       lpc_frame,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);

  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] HalfLast = DivW'(CLK_DIV / 2 - 1);
  localparam logic [RxAw:0] RxFull = RX_DEPTH[RxAw:0];
  localparam logic [TxAw:0] TxFull = TX_DEPTH[TxAw:0];

  typedef enum logic [3:0] {
    StIdle, StCtdir, StAddr0, StAddr1, StAddr2, StAddr3, StWdata0, StWdata1,
    StTar0, StTar1, StSync, StRdata0, StRdata1, StTar2, StTar3, StSpare
  } lpc_state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic {TxIdle, TxBusy} tx_state_e;

  // LPC side
  lpc_state_e lpc_state_q;
  logic [11:0] addr_q;
  logic [2:0]  off_q;
  logic        is_wr_q;
  logic [7:0]  wdata_q, rdata_q, rd_mux;
  logic        ad_oe_q;
  logic [3:0]  ad_out_q;
  logic        addr_hit, rd_fire, wr_fire, lsr_rd;

  // Registers
  logic [1:0] ier_q;
  logic [7:0] scr_q;
  logic       oe_q, fe_q, oe_set, fe_set;
  logic       temt;
  logic [7:0] lsr;

  // RX FIFO
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RxAw-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RxAw:0] rx_count_q;
  logic          rx_empty, rx_full, rx_push, rx_pop;

  // TX FIFO
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TxAw-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TxAw:0] tx_count_q;
  logic          tx_empty, tx_full, tx_push, tx_pop;

  // RX receiver
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q;
  logic [DivW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_stop_hit;

  // TX shifter
  tx_state_e       tx_state_q;
  logic [DivW-1:0] tx_cnt_q;
  logic [3:0]      tx_left_q;
  logic [8:0]      tx_shift_q;
  logic            tx_q;

  // Bus is released combinationally when the host asserts LFRAME# (abort).
  assign lpc_ad = (ad_oe_q && lpc_frame) ? ad_out_q : 4'bzzzz;

  assign addr_hit = ({addr_q, lpc_ad[3]} == BASE_ADDR[15:3]);
  assign rd_fire  = (lpc_state_q == StAddr3) && lpc_frame && !is_wr_q && addr_hit;
  assign wr_fire  = (lpc_state_q == StSync) && lpc_frame && is_wr_q;
  assign lsr_rd   = rd_fire && (lpc_ad[2:0] == 3'd5);

  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == RxFull);
  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == TxFull);

  assign temt = tx_empty && (tx_state_q == TxIdle);
  assign lsr  = {1'b0, temt, temt, 1'b0, fe_q, 1'b0, oe_q, !rx_empty};
  assign irq  = (ier_q[0] && !rx_empty) || (ier_q[1] && temt);

  // Read data mux, indexed by the last address nibble during ADDR3.
  always_comb begin
    rd_mux = 8'h00;
    case (lpc_ad[2:0])
      3'd0:    rd_mux = rx_empty ? 8'hFF : rx_mem[rx_rd_ptr_q];
      3'd1:    rd_mux = {6'b0, ier_q};
      3'd5:    rd_mux = lsr;
      3'd7:    rd_mux = scr_q;
      default: rd_mux = 8'h00;
    endcase
  end

  // LPC protocol FSM; lpc_ad drive state is registered alongside the state.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      lpc_state_q <= StIdle;
      addr_q      <= '0;
      off_q       <= '0;
      is_wr_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
    end else if (lpc_state_q != StIdle && !lpc_frame) begin
      // Abort: drop the cycle and treat this clock as a possible START.
      ad_oe_q     <= 1'b0;
      lpc_state_q <= (lpc_ad == 4'b0000) ? StCtdir : StIdle;
    end else begin
      unique case (lpc_state_q)
        StIdle: if (!lpc_frame && lpc_ad == 4'b0000) lpc_state_q <= StCtdir;
        StCtdir: begin
          if (lpc_ad == 4'b0000) begin
            is_wr_q     <= 1'b0;
            lpc_state_q <= StAddr0;
          end else if (lpc_ad == 4'b0010) begin
            is_wr_q     <= 1'b1;
            lpc_state_q <= StAddr0;
          end else begin
            lpc_state_q <= StIdle;
          end
        end
        StAddr0: begin
          addr_q      <= {addr_q[7:0], lpc_ad};
          lpc_state_q <= StAddr1;
        end
        StAddr1: begin
          addr_q      <= {addr_q[7:0], lpc_ad};
          lpc_state_q <= StAddr2;
        end
        StAddr2: begin
          addr_q      <= {addr_q[7:0], lpc_ad};
          lpc_state_q <= StAddr3;
        end
        StAddr3: begin
          if (addr_hit) begin
            off_q <= lpc_ad[2:0];
            if (is_wr_q) begin
              lpc_state_q <= StWdata0;
            end else begin
              rdata_q     <= rd_mux;
              lpc_state_q <= StTar0;
            end
          end else begin
            lpc_state_q <= StIdle;
          end
        end
        StWdata0: begin
          wdata_q[3:0] <= lpc_ad;
          lpc_state_q  <= StWdata1;
        end
        StWdata1: begin
          wdata_q[7:4] <= lpc_ad;
          lpc_state_q  <= StTar0;
        end
        StTar0: lpc_state_q <= StTar1;
        StTar1: begin
          ad_oe_q     <= 1'b1;
          ad_out_q    <= 4'b0000;
          lpc_state_q <= StSync;
        end
        StSync: begin
          if (is_wr_q) begin
            ad_out_q    <= 4'b1111;
            lpc_state_q <= StTar2;
          end else begin
            ad_out_q    <= rdata_q[3:0];
            lpc_state_q <= StRdata0;
          end
        end
        StRdata0: begin
          ad_out_q    <= rdata_q[7:4];
          lpc_state_q <= StRdata1;
        end
        StRdata1: begin
          ad_out_q    <= 4'b1111;
          lpc_state_q <= StTar2;
        end
        StTar2: begin
          ad_oe_q     <= 1'b0;
          lpc_state_q <= StTar3;
        end
        StTar3: lpc_state_q <= StIdle;
        default: begin
          ad_oe_q     <= 1'b0;
          lpc_state_q <= StIdle;
        end
      endcase
    end
  end

  assign rx_pop  = rd_fire && (lpc_ad[2:0] == 3'd0) && !rx_empty;
  assign tx_push = wr_fire && (off_q == 3'd0) && (!tx_full || tx_pop);

  assign rx_stop_hit = (rx_state_q == RxStop) && (rx_cnt_q == '0);
  // A same-clock RBR pop frees a slot, so a full FIFO does not overrun then.
  assign rx_push = rx_stop_hit && rx_sync_q && (!rx_full || rx_pop);
  assign oe_set  = rx_stop_hit && rx_sync_q && rx_full && !rx_pop;
  assign fe_set  = rx_stop_hit && !rx_sync_q;

  // IER, SCR and sticky LSR error flags; a new error wins over a read-clear.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      ier_q <= '0;
      scr_q <= '0;
      oe_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      if (wr_fire && off_q == 3'd1) ier_q <= wdata_q[1:0];
      if (wr_fire && off_q == 3'd7) scr_q <= wdata_q;
      oe_q <= (oe_q && !lsr_rd) || oe_set;
      fe_q <= (fe_q && !lsr_rd) || fe_set;
    end
  end

  // FIFO storage (no reset needed; validity tracked by the counts).
  always_ff @(posedge lpc_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_shift_q;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata_q;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + 1'b1;
        2'b01:   rx_count_q <= rx_count_q - 1'b1;
        default: rx_count_q <= rx_count_q;
      endcase
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + 1'b1;
        2'b01:   tx_count_q <= tx_count_q - 1'b1;
        default: tx_count_q <= tx_count_q;
      endcase
    end
  end

  // Two-flop synchroniser plus edge-history flop on the serial input.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver: half-bit start check, then mid-bit samples of data and stop.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= HalfLast;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (rx_sync_q) begin
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q   <= DivLast;
            rx_bit_q   <= '0;
            rx_state_q <= RxData;
          end
        end
        RxData: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= DivLast;
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end
        end
        RxStop: begin
          if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
          else                rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Load a new frame when idle, or straight after a stop bit for back-to-back bytes.
  assign tx_pop = !tx_empty &&
                  ((tx_state_q == TxIdle) || (tx_cnt_q == '0 && tx_left_q == '0));

  // Transmitter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
    end else if (tx_pop) begin
      tx_q       <= 1'b0;
      tx_shift_q <= {1'b1, tx_mem[tx_rd_ptr_q]};
      tx_left_q  <= 4'd9;
      tx_cnt_q   <= DivLast;
      tx_state_q <= TxBusy;
    end else if (tx_state_q == TxBusy) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end else if (tx_left_q != '0) begin
        tx_q       <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_left_q  <= tx_left_q - 1'b1;
        tx_cnt_q   <= DivLast;
      end else begin
        tx_q       <= 1'b1;
        tx_state_q <= TxIdle;
      end
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_lpc_uart_fifo.sv
// Directed bench for lpc_uart_fifo: LPC register access, RX/TX framing, overrun,
// framing error, aborted and unclaimed cycles.
module tb_lpc_uart_fifo;

  localparam int unsigned Div  = 286;
  localparam logic [15:0] Base = 16'h03F8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame = 1'b1;
  logic       rx = 1'b1;
  logic       host_oe = 1'b0;
  logic [3:0] host_ad = 4'h0;
  wire  [3:0] lpc_ad;
  wire        tx;
  wire        irq;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  assign lpc_ad = host_oe ? host_ad : 4'bzzzz;
  pullup (lpc_ad[0]);
  pullup (lpc_ad[1]);
  pullup (lpc_ad[2]);
  pullup (lpc_ad[3]);

  lpc_uart_fifo #(
    .BASE_ADDR(Base),
    .CLK_DIV  (Div),
    .RX_DEPTH (4),
    .TX_DEPTH (4)
  ) dut (
    .lpc_clk  (clk),
    .lpc_rst  (rst_n),
    .lpc_ad   (lpc_ad),
    .lpc_frame(frame),
    .uart_rx  (rx),
    .uart_tx  (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LPC I/O cycle; reports read data, whether SYNC was seen, and the commit cycle.
  task automatic lpc_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd, output bit synced,
                           output int unsigned commit);
    rd = 8'hxx;
    synced = 1'b0;
    commit = 0;
    @(negedge clk); frame = 1'b0; host_oe = 1'b1; host_ad = 4'h0;
    @(negedge clk); frame = 1'b1; host_ad = wr ? 4'h2 : 4'h0;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk); host_ad = addr[i*4 +: 4];
    end
    if (wr) begin
      @(negedge clk); host_ad = wd[3:0];
      @(negedge clk); host_ad = wd[7:4];
    end
    @(negedge clk); host_ad = 4'hF;
    @(negedge clk); host_oe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (lpc_ad === 4'b0000) begin
        synced = 1'b1;
        commit = cyc + 1;
        break;
      end
    end
    if (synced && !wr) begin
      @(negedge clk); rd[3:0] = lpc_ad;
      @(negedge clk); rd[7:4] = lpc_ad;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] d;
    bit s;
    int unsigned c;
    lpc_cycle(1'b0, Base + {13'd0, off}, 8'h00, d, s, c);
    chk({tag, "_sync"}, {7'd0, s}, 8'd1);
    chk(tag, d, exp);
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] v, output int unsigned c);
    logic [7:0] d;
    bit s;
    lpc_cycle(1'b1, Base + {13'd0, off}, v, d, s, c);
    chk("wr_sync", {7'd0, s}, 8'd1);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Div) @(negedge clk);
    end
    rx = stop;
    repeat (Div) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  txbits;
    logic [7:0]  d;
    bit          s;
    int unsigned c;
    bit          quiet;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {7'd0, tx}, 8'd1);
    chk("rst_irq", {7'd0, irq}, 8'd0);
    chk("rst_ad", {4'd0, lpc_ad}, 8'h0F);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk("lsr_reset", 3'd5, 8'h60);
    rd_chk("rbr_empty", 3'd0, 8'hFF);
    rd_chk("ier_reset", 3'd1, 8'h00);
    rd_chk("scr_reset", 3'd7, 8'h00);
    chk("tx_idle", {7'd0, tx}, 8'd1);

    // Single RX byte with RX interrupt enabled
    wr_reg(3'd1, 8'hFD, c);
    rd_chk("ier_rb", 3'd1, 8'h01);
    chk("irq_rx_empty", {7'd0, irq}, 8'd0);
    uart_send(8'h5A, 1'b1);
    chk("irq_rx_data", {7'd0, irq}, 8'd1);
    rd_chk("lsr_dr", 3'd5, 8'h61);
    rd_chk("rbr_5a", 3'd0, 8'h5A);
    rd_chk("lsr_after_pop", 3'd5, 8'h60);
    chk("irq_rx_drained", {7'd0, irq}, 8'd0);
    wr_reg(3'd1, 8'h02, c);
    chk("irq_temt", {7'd0, irq}, 8'd1);
    wr_reg(3'd1, 8'h00, c);

    // TX byte A5: start, 1,0,1,0,0,1,0,1, stop
    wr_reg(3'd0, 8'hA5, c);
    rd_chk("lsr_tx_busy", 3'd5, 8'h00);
    txbits = 10'b1_1010_0101_0;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(c + 2 + Div * i + Div / 2);
      chk($sformatf("tx_bit%0d", i), {7'd0, tx}, {7'd0, txbits[i]});
    end
    wait_cyc(c + 2 + Div * 10 + 2);
    rd_chk("lsr_tx_done", 3'd5, 8'h60);

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) uart_send(8'(i), 1'b1);
    rd_chk("lsr_oe", 3'd5, 8'h63);
    rd_chk("lsr_oe_clr", 3'd5, 8'h61);
    for (int i = 1; i <= 4; i++) rd_chk($sformatf("rbr_%0d", i), 3'd0, 8'(i));
    rd_chk("rbr_drained", 3'd0, 8'hFF);

    // Framing error
    uart_send(8'h33, 1'b0);
    rd_chk("lsr_fe", 3'd5, 8'h68);
    rd_chk("rbr_fe_empty", 3'd0, 8'hFF);
    rd_chk("lsr_fe_clr", 3'd5, 8'h60);

    // Aborted IORD BASE+7: LFRAME# low during ADDR2, bus must stay released
    @(negedge clk); frame = 1'b0; host_oe = 1'b1; host_ad = 4'h0;
    @(negedge clk); frame = 1'b1; host_ad = 4'h0;
    @(negedge clk); host_ad = Base[15:12];
    @(negedge clk); host_ad = Base[11:8];
    @(negedge clk); frame = 1'b0; host_ad = 4'hF;
    @(negedge clk); frame = 1'b1; host_oe = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (lpc_ad !== 4'b1111) quiet = 1'b0;
    end
    chk("abort_no_drive", {7'd0, quiet}, 8'd1);

    // Scratch register round trip
    wr_reg(3'd7, 8'h3C, c);
    rd_chk("scr_3c", 3'd7, 8'h3C);

    // Unclaimed address
    lpc_cycle(1'b0, 16'h02F8, 8'h00, d, s, c);
    chk("miss_no_sync", {7'd0, s}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lpc_uart_fifo.md
Name: lpc_uart_fifo

Overview:
- Parametrised LPC I/O-cycle target exposing a 16550-subset UART, with configurable base address, bit period and RX/TX FIFO depths.
- Successor to the fixed single-byte LPC UART device.
- Adds a TX FIFO, overrun and framing-error reporting, a scratch register, and a level interrupt.
- Sits directly on the host LPC bus; drives the board UART pins.

Parameters:
- BASE_ADDR, 16'h03F8: I/O base address. The block decodes BASE_ADDR+0 through BASE_ADDR+7.
- CLK_DIV, 286: lpc_clk cycles per UART bit. Must be at least 8.
- RX_DEPTH, 4: RX FIFO entries. Power of two, at least 2.
- TX_DEPTH, 4: TX FIFO entries. Power of two, at least 2.

Ports:
- lpc_clk  in  1  LPC clock; the only clock.
- lpc_rst  in  1  Asynchronous, active-low reset.
- lpc_ad  inout  4  LPC LAD[3:0]. Tri-stated unless this target owns the bus.
- lpc_frame  in  1  LFRAME#, active low.
- uart_rx  in  1  Serial input; idles high.
- uart_tx  out  1  Serial output; idles high.
- irq  out  1  Level interrupt, active high.

Behaviour:
- Clocking and reset: one clock, lpc_clk. lpc_rst is asynchronous and active-low.
- Reset values: uart_tx=1, irq=0, lpc_ad=Z, both FIFOs empty, IER=0, SCR=0, LSR error flags clear. All state machines go to IDLE.
- LPC protocol FSM states: IDLE, CTDIR, ADDR0-3, WDATA0-1, TAR0-1, SYNC, RDATA0-1, TAR2-3.
- START: lpc_frame=0 with lpc_ad=0000 arms CTDIR on the next clock. A START nibble other than 0000 keeps the FSM in IDLE.
- CTDIR: 0000 = IORD, 0010 = IOWR. Any other value returns to IDLE without driving.
- ADDR: four nibbles, MSB first. If addr[15:3] != BASE_ADDR[15:3], the cycle is ignored: return to IDLE and never drive lpc_ad.
- IOWR: WDATA0 = data[3:0], WDATA1 = data[7:4]. Register commit happens at the end of SYNC.
- TAR0-1 (host turnaround): target does not drive.
- SYNC: target drives 0000 for exactly one cycle (no wait states).
- IORD: RDATA0 drives data[3:0], RDATA1 drives data[7:4].
- TAR2: target drives 1111. TAR3: target floats. Then back to IDLE.
- Abort: lpc_frame=0 in any state after CTDIR → tri-state immediately, discard the cycle with no register side effects, and re-evaluate as a START.
- Registers (offset from BASE_ADDR):
  - +0 read RBR: pops the RX FIFO. Returns 8'hFF when empty; no pop occurs.
  - +0 write THR: pushes the TX FIFO. Write is silently dropped when the FIFO is full.
  - +1 IER: bit0 = RX data interrupt enable, bit1 = TX-empty interrupt enable. Bits 7:2 read 0.
  - +5 LSR, read-only:
    - bit0 DR = RX FIFO non-empty.
    - bit1 OE = overrun.
    - bit3 FE = framing error.
    - bit5 = bit6 = TX FIFO empty AND shifter idle.
    - Other bits read 0.
    - OE and FE clear on the read of LSR.
  - +7 SCR: 8-bit read/write scratch register.
  - Other offsets: reads return 00, writes are ignored.
- Read data is sampled at the end of ADDR3 (the RBR pop happens then). The value stays stable through RDATA1.
- RX path:
  - 2-FF synchroniser on uart_rx.
  - A falling edge starts a bit counter. Start bit is re-sampled at CLK_DIV/2; if high, it is a false start and the receiver returns to idle.
  - Data is sampled at the middle of each bit, LSB first.
  - Stop bit = 0 → byte discarded, FE set.
  - Stop bit = 1 and FIFO full → byte discarded, OE set.
  - Otherwise push. The push is visible in LSR DR 1 clock after the stop-bit sample.
- TX path:
  - Shifter loads from the TX FIFO when idle and the FIFO is non-empty.
  - Frame: 1 start bit, 8 data bits LSB first, 1 stop bit; each bit is CLK_DIV clocks.
  - Back-to-back bytes follow with no idle gap.
  - First start bit appears within 2 clocks after the THR commit.
- Simultaneous push and pop on the same FIFO in the same clock: both take effect and the count is unchanged. A pop that would hit a full-FIFO-plus-incoming-byte case is treated as done first, so no overrun.
- Pointers wrap modulo depth. Count width is clog2(DEPTH)+1.
- irq = (IER[0] & DR) | (IER[1] & LSR[6]). Combinational from registered state.
- Reset asserted mid-frame: uart_tx goes to 1 and lpc_ad to Z immediately (asynchronous); any partial RX byte is lost.

Test Plan:
- Reset, then IORD BASE+5 → 8'h60. IORD BASE+0 → 8'hFF. uart_tx stays 1 throughout.
- uart_rx frame 8'h5A at CLK_DIV=286 → LSR reads 8'h61. RBR reads 8'h5A. LSR then reads 8'h60.
- IOWR BASE+0 with 8'hA5 → LSR reads 8'h00 immediately. uart_tx shows bits 0,1,0,1,0,0,1,0,1,1 at 286-clock spacing. LSR reads 8'h60 after 2860 clocks.
- Send RX_DEPTH+1 bytes 01..05 without reading → LSR reads 8'h63. The next LSR read reads 8'h61. RBR yields 01,02,03,04, then FF.
- Stop bit forced 0 on frame 8'h33 → LSR reads 8'h68. The FIFO stays empty.
- IORD BASE+7 with lpc_frame pulsed low in ADDR2 → lpc_ad never driven. The following IOWR BASE+7 8'h3C then IORD BASE+7 returns 8'h3C. An IORD to 16'h02F8 gets no SYNC.
